mem_stage_sequencer: RTL

//  Multi-cycle controller for the MEM stage of the pipelined LC-3b. It sequences data-memory

---
 rtl/mem_stage_sequencer_pkg.sv | 52 +++++
 rtl/byte_lane_unit.sv | 34 +++
 rtl/mem_stage_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sequencer_pkg.sv
// Shared LC-3b types for the MEM-stage sequencer: opcodes, sequencer states and opcode class helpers.
package mem_stage_sequencer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } lc3b_memseq_state;

  function automatic logic is_mem_op(input lc3b_opcode op);
    case (op)
      OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI, OP_TRAP: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_store(input lc3b_opcode op);
    return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

  function automatic logic is_byte_op(input lc3b_opcode op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for data-memory accesses: address alignment, lane enables,
// store byte replication and sign-extended load byte selection.
module byte_lane_unit
  import mem_stage_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_byte,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_address,
  output logic [1:0]        o_byte_enable,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_load_data
);

  logic [7:0] w_sel_byte;

  assign w_sel_byte = i_target[0] ? i_rdata[15:8] : i_rdata[7:0];

  always_comb begin
    o_address     = {i_target[ADDR_W-1:1], 1'b0};
    o_byte_enable = 2'b11;
    o_wdata       = i_wdata;
    o_load_data   = i_rdata;
    if (i_byte) begin
      // Byte accesses keep the odd address so the cache sees the real lane.
      o_address     = i_target;
      o_byte_enable = i_target[0] ? 2'b10 : 2'b01;
      o_wdata       = {i_wdata[7:0], i_wdata[7:0]};
      o_load_data   = {{8{w_sel_byte[7]}}, w_sel_byte};
    end
  end

endmodule

// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer for the pipelined LC-3b: runs pointer and data phases against the
// data cache, stalls the pipeline while an access is outstanding and returns the result to WB.
module mem_stage_sequencer
  import mem_stage_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [3:0]  opcode,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        stall,
  output logic [15:0] rdata_out,
  output logic        rdata_valid,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lc3b_memseq_state  r_state;
  lc3b_memseq_state  w_state_nxt;
  lc3b_opcode        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_timeout;

  lc3b_opcode        w_op_in;
  logic              w_accept;
  logic              w_timeout_hit;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_lane_addr;
  logic [1:0]        w_lane_be;
  logic [DATA_W-1:0] w_lane_wdata;
  logic [DATA_W-1:0] w_load_data;

  assign w_op_in  = lc3b_opcode'(opcode);
  assign w_accept = valid & is_mem_op(w_op_in);
  assign w_target = is_indirect(r_op) ? r_ptr : r_addr;
  assign rdata_out = r_result;

  // Watchdog fires on the last allowed waiting cycle; a same-cycle resp takes priority.
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !dmem_resp;

  byte_lane_unit u_byte_lane (
    .i_target      (w_target),
    .i_byte        (is_byte_op(r_op)),
    .i_wdata       (r_wdata),
    .i_rdata       (dmem_rdata),
    .o_address     (w_lane_addr),
    .o_byte_enable (w_lane_be),
    .o_wdata       (w_lane_wdata),
    .o_load_data   (w_load_data)
  );

  // Next-state and request/handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    stall            = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = '0;
    rdata_valid      = 1'b0;
    timeout_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall       = 1'b1;
          w_state_nxt = is_indirect(w_op_in) ? S_PTR : S_DATA;
        end
      end
      S_PTR: begin
        stall            = 1'b1;
        dmem_read        = 1'b1;
        dmem_address     = {r_addr[ADDR_W-1:1], 1'b0};
        dmem_byte_enable = 2'b11;
        if (dmem_resp)          w_state_nxt = S_DATA;
        else if (w_timeout_hit) w_state_nxt = S_DONE;
      end
      S_DATA: begin
        stall            = 1'b1;
        dmem_read        = ~is_store(r_op);
        dmem_write       = is_store(r_op);
        dmem_address     = w_lane_addr;
        dmem_wdata       = w_lane_wdata;
        dmem_byte_enable = w_lane_be;
        if (dmem_resp || w_timeout_hit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        rdata_valid = 1'b1;
        timeout_err = r_timeout;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, latched instruction fields, pointer/result capture and wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= OP_BR;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ptr      <= '0;
      r_result   <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= w_op_in;
            r_addr  <= addr;
            r_wdata <= wdata;
          end
        end
        S_PTR: begin
          if (dmem_resp) begin
            r_ptr <= dmem_rdata;
          end else if (w_timeout_hit) begin
            r_result  <= '0;
            r_timeout <= 1'b1;
          end
        end
        S_DATA: begin
          if (dmem_resp) begin
            r_result <= is_store(r_op) ? '0 : w_load_data;
          end else if (w_timeout_hit) begin
            r_result  <= '0;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
      if (w_state_nxt != r_state) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_PTR) || (r_state == S_DATA)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule
